// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: 16-deep FIFO of marker-tagged bytes
// with read-side packet length tracking so data_out idles at zero between packets.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int LEN_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  logic [WIDTH:0]   mem_r [DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic [LEN_W:0]   pkt_cnt_r;
  logic [WIDTH-1:0] data_out_r;

  logic             empty_s;
  logic             full_s;
  logic             wr_fire_s;
  logic             rd_fire_s;
  logic [WIDTH:0]   rd_word_s;
  logic [LEN_W:0]   hdr_len_s;

  // Occupancy flags and accepted-transfer qualifiers from the pre-edge pointers
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    wr_fire_s = write_enb && !full_s;
    rd_fire_s = read_enb && !empty_s;
    rd_word_s = mem_r[rd_ptr_r[PTR_W-1:0]];
    // Header length counts payload bytes; the +1 covers the trailing parity byte
    hdr_len_s = {1'b0, rd_word_s[WIDTH-1 -: LEN_W]} + (LEN_W+1)'(1);
  end

  // Write side: storage array and write pointer
  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
    end else if (wr_fire_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= {lfd_state, data_in};
      wr_ptr_r                   <= wr_ptr_r + (PTR_W+1)'(1);
    end
  end

  // Read side: read pointer, registered data and packet byte countdown
  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      rd_ptr_r   <= '0;
      pkt_cnt_r  <= '0;
      data_out_r <= '0;
    end else if (rd_fire_s) begin
      rd_ptr_r   <= rd_ptr_r + (PTR_W+1)'(1);
      data_out_r <= rd_word_s[WIDTH-1:0];
      if (rd_word_s[WIDTH]) begin
        pkt_cnt_r <= hdr_len_s;
      end else if (pkt_cnt_r != '0) begin
        pkt_cnt_r <= pkt_cnt_r - (LEN_W+1)'(1);
      end
    end else if (pkt_cnt_r == '0) begin
      data_out_r <= '0;
    end
  end

  assign data_out = data_out_r;
  assign full     = full_s;
  assign empty    = empty_s;

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: bytes are queued when a write is accepted
// and compared against data_out on the cycle after the matching read.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         occ = 0;
  logic       rd_acc;
  logic [7:0] exp_rd;

  router_fifo #(.WIDTH(8), .DEPTH(16), .PTR_W(4), .LEN_W(6)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  // One clock of stimulus; the occupancy model decides acceptance from pre-edge state
  task automatic step(input logic w, input logic lfd, input logic [7:0] d, input logic r);
    bit pf, pe;
    pf = (occ == 16);
    pe = (occ == 0);
    write_enb = w; lfd_state = lfd; data_in = d; read_enb = r;
    rd_acc = r && !pe;
    if (rd_acc) exp_rd = sb.pop_front();
    if (w && !pf) sb.push_back(d);
    occ = occ + ((w && !pf) ? 1 : 0) - (rd_acc ? 1 : 0);
    @(posedge clock); #1;
    write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
  endtask

  task automatic model_clear();
    sb.delete();
    occ = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom_range(255)), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    resetn = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    model_clear();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h exp 00", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    resetn = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_read_empty got %h exp 00", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_read_empty_flag got %b exp 1", empty); end
  endtask

  task automatic test_single_packet();
    logic [7:0] pkt[5];
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), pkt[i], 1'b0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL pkt_not_empty got %b exp 0", empty); end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (!rd_acc || data_out !== exp_rd || exp_rd !== pkt[i]) begin
        errors++; $display("FAIL pkt_read%0d got %h exp %h", i, data_out, pkt[i]);
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pkt_empty_after got %b exp 1", empty); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL pkt_idle_zero got %h exp 00", data_out); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i * 7 + 3), 1'b0);
      if (i == 14) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_at16 got %b exp 1", full); end
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_after_drop got %b exp 1", full); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (!rd_acc || data_out !== exp_rd) begin
        errors++; $display("FAIL full_read%0d got %h exp %h", i, data_out, exp_rd);
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained got %b exp 1", empty); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    step(1'b1, 1'b0, 8'hEE, 1'b1);
    checks++; if (!rd_acc || data_out !== exp_rd || exp_rd !== 8'hA0) begin
      errors++; $display("FAIL simul_full_read got %h exp a0", data_out);
    end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL simul_full_flag got %b exp 0", full); end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== exp_rd) begin
        errors++; $display("FAIL simul_drain%0d got %h exp %h", i, data_out, exp_rd);
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_drop_check got %b exp 1", empty); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h5C, 1'b1);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL simul_empty_data got %h exp 00", data_out); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL simul_empty_flag got %b exp 0", empty); end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (data_out !== 8'h5C) begin errors++; $display("FAIL simul_stored got %h exp 5c", data_out); end
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_soft_reset();
    step(1'b1, 1'b1, 8'h28, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== exp_rd) begin
        errors++; $display("FAIL srst_pre%0d got %h exp %h", i, data_out, exp_rd);
      end
    end
    soft_reset = 1'b1; write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h99;
    @(posedge clock); #1;
    soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0; data_in = 8'h00;
    model_clear();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL srst_data got %h exp 00", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL srst_empty got %b exp 1", empty); end
    step(1'b1, 1'b1, 8'h04, 1'b0);
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    step(1'b1, 1'b0, 8'h5E, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (!rd_acc || data_out !== exp_rd) begin
        errors++; $display("FAIL srst_post%0d got %h exp %h", i, data_out, exp_rd);
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL srst_pkt_end got %h exp 00", data_out); end
  endtask

  task automatic test_wrap();
    int fulls = 0;
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        1:       step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        3:       step(1'b0, 1'b0, 8'h00, 1'b1);
        default: step(1'b1, 1'b0, 8'(8'h10 + i), 1'b1);
      endcase
      if (full) fulls++;
      if (rd_acc) begin
        checks++; if (data_out !== exp_rd) begin
          errors++; $display("FAIL wrap_read%0d got %h exp %h", i, data_out, exp_rd);
        end
      end
    end
    while (occ > 0) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (data_out !== exp_rd) begin
        errors++; $display("FAIL wrap_drain got %h exp %h", data_out, exp_rd);
      end
    end
    checks++; if (fulls != 0) begin errors++; $display("FAIL wrap_full_seen got %0d exp 0", fulls); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    data_in = 8'h00; read_enb = 1'b0; rd_acc = 1'b0; exp_rd = 8'h00;
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    test_reset();
    test_single_packet();
    test_full();
    test_simultaneous();
    test_soft_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-port output buffer of the 1x3 router: three instances, one per destination, sit between the router's register/FSM stage and the data_out_0/1/2 pins.
- Stores header, payload and parity bytes, each tagged with a header marker bit.
- Tracks packet length on the read side so data_out returns to 0 once the parity byte has been read.
- Supports a per-port soft reset, which the router's sync block raises when the read side times out.

Parameters:
- WIDTH, 8, data byte width (stored word is WIDTH+1 bits; MSB is the header marker)
- DEPTH, 16, number of words; must be a power of 2
- PTR_W, 4, log2(DEPTH); pointers are PTR_W+1 bits wide
- LEN_W, 6, width of the header length field, data[7:2]

Ports:
- clock  in  1  single clock; all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- soft_reset  in  1  synchronous flush of this port, active-high
- write_enb  in  1  write request from router FSM/register stage
- lfd_state  in  1  high on the write that carries the header byte
- data_in  in  WIDTH  byte to store
- read_enb  in  1  read request from the downstream consumer (read_enb_N)
- data_out  out  WIDTH  registered read data (data_out_N)
- full  out  1  no free word
- empty  out  1  no stored word; the router drives vld_out_N = !empty

Behaviour:
- Reset: resetn low at a clock edge clears all memory words, wr_ptr=0, rd_ptr=0, pkt_cnt=0 and data_out=0. After the edge, empty=1 and full=0. resetn has priority over everything else.
- Soft reset: soft_reset high (with resetn high) has the same effect as reset: memory cleared, pointers 0, pkt_cnt 0, data_out 0. It has priority over write_enb and read_enb in the same cycle.
- Flags: combinational from the current pointers.
  - empty = (wr_ptr == rd_ptr)
  - full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) and (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0])
- Write: write_enb && !full stores mem[wr_ptr[PTR_W-1:0]] <= {lfd_state, data_in} and increments wr_ptr.
  - A write while full is dropped silently; wr_ptr is unchanged.
- Read: read_enb && !empty loads data_out <= mem[rd_ptr][WIDTH-1:0] (1-cycle latency) and increments rd_ptr.
  - A read while empty leaves rd_ptr unchanged.
- Packet counter (pkt_cnt, LEN_W+1 bits):
  - On a read of a word whose marker bit = 1: pkt_cnt <= word[7:2] + 1, covering the payload plus the parity byte.
  - On a read of a non-header word with pkt_cnt != 0: pkt_cnt decrements.
- data_out when no read fires: if pkt_cnt == 0, data_out <= 0; otherwise data_out holds its value.
  - So data_out returns to 0 on the first idle cycle after the parity byte is read.
- Simultaneous write and read:
  - Both are evaluated against the pre-edge flags.
  - When full: the read succeeds and the write is dropped (full is sampled before the read frees space).
  - When empty: the write succeeds and the read is ignored.
  - Otherwise both happen; the occupancy is unchanged.
- Wrap-around: the low PTR_W pointer bits index memory and roll over 15->0; the MSB toggles on each wrap, so full and empty are distinguishable.
- Length-0 header: pkt_cnt loads 1, so exactly one further read (the parity byte) ends the packet.
- Marker bits of stored words are never driven on data_out.

Test Plan:
- Reset: drive resetn=0 for 2 cycles after random writes -> data_out=0, empty=1, full=0; a subsequent read_enb=1 leaves data_out=0.
- Single packet: write header 8'h0D (length 3, address 1) with lfd_state=1, then payload 11,22,33 and parity 44; then read 5 times back-to-back -> data_out = 0D,11,22,33,44 on consecutive cycles; empty=1 after the 5th read; data_out=0 on the next idle cycle.
- Full: 16 writes with no reads -> full=1 after the 16th; a 17th write (8'hFF) is dropped; 16 reads return the original 16 bytes in order, then empty=1.
- Simultaneous: at full, assert read_enb and write_enb together -> one byte read, write dropped, full=0 next cycle; at empty, both asserted -> write stored, data_out unchanged, empty=0 next cycle.
- Soft reset mid-packet: after the header (length 10) and 2 payload bytes have been read, pulse soft_reset for 1 cycle -> data_out=0, empty=1, pkt_cnt=0; a new header-plus-1-byte packet then reads correctly.
- Wrap-around: run 40 write/read pairs with occupancy held between 1 and 3 -> data is returned in order across 2 pointer wraps, and full is never asserted.
